// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_pkg
// Purpose  : Shared constants for the switch debouncer. Holds the default
//            timing for a 100 MHz board clock, the default channel count and
//            counter width, and the channel index map the downstream ALU uses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

  // 10 ms of stability at 100 MHz.
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
  // 2^20 = 1_048_576 covers DEFAULT_STABLE_CYCLES.
  localparam int DEFAULT_CNT_W         = 20;
  localparam int DEFAULT_WIDTH         = 7;

  // Channel index map: ALU op select, data-group select, result-half select.
  localparam int OP_LSB            = 0;
  localparam int OP_MSB            = 2;
  localparam int DATA_SW_LSB       = 3;
  localparam int DATA_SW_MSB       = 5;
  localparam int RESULT_SWITCH_BIT = 6;

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_if
// Purpose  : Bundles the raw switch inputs and the conditioned outputs of the
//            switch debouncer.
// Ports    : SW_DB_raw        [WIDTH] raw asynchronous switch levels
//            SW_DB_level      [WIDTH] debounced levels
//            SW_DB_rise       [WIDTH] one-cycle 0->1 pulses
//            SW_DB_fall       [WIDTH] one-cycle 1->0 pulses
//            SW_DB_any_change [1]     OR of all rise/fall bits
// Modports : master - switch source / consumer side (drives raw)
//            slave  - debouncer side (drives levels and pulses)
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] SW_DB_raw;
  logic [WIDTH-1:0] SW_DB_level;
  logic [WIDTH-1:0] SW_DB_rise;
  logic [WIDTH-1:0] SW_DB_fall;
  logic             SW_DB_any_change;

  modport master (
    output SW_DB_raw,
    input  SW_DB_level,
    input  SW_DB_rise,
    input  SW_DB_fall,
    input  SW_DB_any_change
  );

  modport slave (
    input  SW_DB_raw,
    output SW_DB_level,
    output SW_DB_rise,
    output SW_DB_fall,
    output SW_DB_any_change
  );

endinterface : switch_debouncer_if
`default_nettype wire

// File: rtl/switch_debouncer_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One switch channel: 2-flop synchroniser, stability counter,
//            debounced level register and registered rise/fall pulses.
// Ports    : clk   [1] board clock
//            rst   [1] synchronous active-high reset
//            raw   [1] asynchronous raw switch level
//            level [1] debounced level
//            rise  [1] one-cycle pulse on a 0->1 level change
//            fall  [1] one-cycle pulse on a 1->0 level change
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  // The counter is only non-zero while the synchronised input disagrees with
  // the debounced level, so it doubles as the MATCH/COUNT state. Any sample
  // that agrees again restarts the count, which is what rejects bounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        // Terminal count bounds the counter, so it can never wrap.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Conditions raw board switches for the ALU. Each channel is
//            synchronised, debounced and given one-cycle edge pulses; the
//            pulses of all channels are ORed into a single change flag.
// Ports    : SW_DB_clk [1] board clock, 100 MHz
//            SW_DB_rst [1] synchronous active-high reset
//            sw_db         switch_debouncer_if.slave
//                          (raw in; level, rise, fall, any_change out)
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,  // >= 2
  parameter int CNT_W         = DEFAULT_CNT_W           // 2^CNT_W >= STABLE_CYCLES
) (
  input  wire                      SW_DB_clk,
  input  wire                      SW_DB_rst,
  switch_debouncer_if.slave        sw_db
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk   (SW_DB_clk),
      .rst   (SW_DB_rst),
      .raw   (sw_db.SW_DB_raw[i]),
      .level (w_level[i]),
      .rise  (w_rise[i]),
      .fall  (w_fall[i])
    );
  end

  assign sw_db.SW_DB_level      = w_level;
  assign sw_db.SW_DB_rise       = w_rise;
  assign sw_db.SW_DB_fall       = w_fall;
  // Built only from registered pulses, so raw never reaches it combinationally.
  assign sw_db.SW_DB_any_change = |{w_rise, w_fall};

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Directed self-checking bench for switch_debouncer with
//            STABLE_CYCLES=4, WIDTH=7, CNT_W=3.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  localparam int WIDTH  = 7;
  localparam int STABLE = 4;
  localparam int CNT_W  = 3;
  // Edges from raw change to level change: 2 sync edges + STABLE count edges.
  localparam int FLIP   = 2 + STABLE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  switch_debouncer_if #(.WIDTH(WIDTH)) bus ();

  switch_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (CNT_W)
  ) u_dut (
    .SW_DB_clk (clk),
    .SW_DB_rst (rst),
    .sw_db     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [6:0] lvl,
                            input logic [6:0] ri, input logic [6:0] fa);
    check({tag, ".level"}, 32'(bus.SW_DB_level), 32'(lvl));
    check({tag, ".rise"},  32'(bus.SW_DB_rise),  32'(ri));
    check({tag, ".fall"},  32'(bus.SW_DB_fall),  32'(fa));
    check({tag, ".any"},   32'(bus.SW_DB_any_change), 32'(((ri | fa) != 7'h0) ? 1 : 0));
  endtask

  // raw has just been changed from the state that gave old_lvl; expect the
  // new level exactly FLIP edges later with a single pulse.
  task automatic expect_flip(input string tag, input logic [6:0] old_lvl,
                             input logic [6:0] new_lvl);
    for (int k = 1; k < FLIP; k++) begin
      tick();
      check({tag, ".hold"}, 32'(bus.SW_DB_level), 32'(old_lvl));
    end
    tick();
    check_outs({tag, ".edge"}, new_lvl, new_lvl & ~old_lvl, old_lvl & ~new_lvl);
    tick();
    check_outs({tag, ".after"}, new_lvl, 7'h00, 7'h00);
  endtask

  initial begin
    bus.SW_DB_raw = 7'h7F;
    rst = 1'b1;

    // Reset with all switches high: outputs stay clear.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("reset", 7'h00, 7'h00, 7'h00);
    end
    rst = 1'b0;
    expect_flip("rst_release", 7'h00, 7'h7F);

    // All switches released.
    bus.SW_DB_raw = 7'h00;
    expect_flip("all_fall", 7'h7F, 7'h00);

    // Clean step on bit 0.
    bus.SW_DB_raw = 7'h01;
    expect_flip("clean_step", 7'h00, 7'h01);

    // Bounce on bit 2: 1,0,1,0 for 2 cycles each, then held 1.
    // The last raw change precedes edge 9, so the flip lands on edge 14.
    for (int p = 0; p < 4; p++) begin
      bus.SW_DB_raw = (p % 2 == 0) ? 7'h05 : 7'h01;
      for (int k = 0; k < 2; k++) begin
        tick();
        check("bounce.hold", 32'(bus.SW_DB_level), 32'h01);
      end
    end
    bus.SW_DB_raw = 7'h05;
    for (int k = 1; k < FLIP; k++) begin
      tick();
      check("bounce.settle", 32'(bus.SW_DB_level), 32'h01);
    end
    tick();
    check_outs("bounce.edge", 7'h05, 7'h04, 7'h00);
    tick();
    check_outs("bounce.after", 7'h05, 7'h00, 7'h00);

    // Bring bit 5 high, then glitch it low for 3 cycles.
    bus.SW_DB_raw = 7'h25;
    expect_flip("set_b5", 7'h05, 7'h25);
    bus.SW_DB_raw = 7'h05;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs("glitch.low", 7'h25, 7'h00, 7'h00);
    end
    bus.SW_DB_raw = 7'h25;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_outs("glitch.back", 7'h25, 7'h00, 7'h00);
    end
    // A second 3-cycle glitch is also rejected only if the counter restarted.
    bus.SW_DB_raw = 7'h05;
    for (int k = 0; k < 3; k++) tick();
    bus.SW_DB_raw = 7'h25;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("glitch2.level", 32'(bus.SW_DB_level), 32'h25);
      check("glitch2.fall",  32'(bus.SW_DB_fall),  32'h00);
    end

    // Bit 1 high, then bits 6 and 1 swap together.
    bus.SW_DB_raw = 7'h27;
    expect_flip("set_b1", 7'h25, 7'h27);
    bus.SW_DB_raw = 7'h65;
    expect_flip("simul", 7'h27, 7'h65);

    // Raw bit 3 rises; reset lands on the third counting edge (edge 5).
    bus.SW_DB_raw = 7'h6D;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midcnt.pre", 32'(bus.SW_DB_level), 32'h65);
    end
    rst = 1'b1;
    tick();
    check_outs("midcnt.rst", 7'h00, 7'h00, 7'h00);
    rst = 1'b0;
    for (int k = 1; k < FLIP; k++) begin
      tick();
      check("midcnt.b3_hold", 32'(bus.SW_DB_level[3]), 32'h0);
      check("midcnt.rise0",   32'(bus.SW_DB_rise), 32'h00);
    end
    tick();
    check_outs("midcnt.edge", 7'h6D, 7'h6D, 7'h00);
    tick();
    check_outs("midcnt.after", 7'h6D, 7'h00, 7'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_switch_debouncer
`default_nettype wire
